cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-client physical-memory arbiter: an I-cache (read only) and a D-cache
// (read or writeback) share one line-wide memory port. One transaction is
// in flight at a time. A tie goes to the requester not granted most recently.
// Command, address and write data are latched at grant, so a client may drop
// its request mid-transaction without disturbing the memory side.
//
// Handshake: a client asserts its read/write level and keeps it asserted
// until it sees its one-cycle resp pulse. The arbiter latches the request on
// the granting edge and drives the pmem command from those registers until
// pmem_resp. pmem_resp is forwarded combinationally to the granted client
// only. A request still held in the cycle after resp is a new request.
`timescale 1ns/1ps

module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    // I-cache side
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    // D-cache side
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    // Physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    // Debug view of the FSM state (0=IDLE, 1=SERVE_I, 2=SERVE_D)
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1: most recent grant was D
    logic                write_q, write_d;     // latched command: 1=write, 0=read
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic                i_active;
    logic                d_active;
    logic                grant_i;
    logic                grant_d;

    // Arbitration: a sole requester wins; on a tie the one not served last wins
    always_comb begin
        i_active = i_pmem_read;
        d_active = d_pmem_read | d_pmem_write;
        grant_i  = i_active & (~d_active | last_d_q);
        grant_d  = d_active & (~i_active | ~last_d_q);
    end

    // Next-state, latch capture and completion handling
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = SERVE_I;
                    write_d = 1'b0;
                    addr_d  = i_pmem_address;
                end else if (grant_d) begin
                    state_d = SERVE_D;
                    // A simultaneous read+write request is taken as a writeback
                    write_d = d_pmem_write;
                    addr_d  = d_pmem_address;
                    if (d_pmem_write) begin
                        wdata_d = d_pmem_wdata;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: commands come only from the latched registers
    always_comb begin
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        unique case (state_q)
            SERVE_I: begin
                pmem_read   = 1'b1;
                i_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                pmem_read   = ~write_q;
                pmem_write  = write_q;
                d_pmem_resp = pmem_resp;
            end
            default: begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign dbg_state    = state_q;

    // State registers; reset abandons any transaction and favours I on first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

`ifndef SYNTHESIS
    // Protocol invariants checked every active cycle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(pmem_read && pmem_write))
                else $error("pmem_read and pmem_write both high");
            assert (!(i_pmem_resp && d_pmem_resp))
                else $error("both client resps high");
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
`timescale 1ns/1ps

module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [1:0]        dbg_state;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [LINE_W-1:0] exp_q[$];   // expected grant order, one entry per transaction

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one cycle; inputs are changed 2ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_pmem_read    = 1'b0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        pmem_resp      = 1'b0;
    endtask

    task automatic wait_grant(output logic [1:0] st);
        int n;
        n = 0;
        tick();
        settle();
        while (dbg_state == S_IDLE && n < 8) begin
            tick();
            settle();
            n++;
        end
        check("granted", {255'd0, dbg_state != S_IDLE}, 256'd1);
        st = dbg_state;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        settle();
    endtask

    logic [1:0]        st;
    logic [LINE_W-1:0] exp_grant;
    logic [LINE_W-1:0] rd_pat;

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        idle_inputs();
        i_pmem_address = '0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;

        // Reset state
        #12;
        check("rst_state", {254'd0, dbg_state}, {254'd0, S_IDLE});
        check("rst_pmem_read", {255'd0, pmem_read}, 256'd0);
        check("rst_pmem_write", {255'd0, pmem_write}, 256'd0);
        check("rst_addr", {224'd0, pmem_address}, 256'd0);
        check("rst_wdata", pmem_wdata, 256'd0);
        do_reset();

        // Read data passthrough on both clients
        rd_pat = {8{$urandom()}};
        pmem_rdata = rd_pat;
        settle();
        check("i_rdata_pass", i_pmem_rdata, rd_pat);
        check("d_rdata_pass", d_pmem_rdata, rd_pat);

        // I-only read, resp three cycles after the command appears
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_1000;
        settle();
        check("i_only_idle_read", {255'd0, pmem_read}, 256'd0);
        tick(); settle();
        check("i_only_state", {254'd0, dbg_state}, {254'd0, S_SERVE_I});
        check("i_only_read", {255'd0, pmem_read}, 256'd1);
        check("i_only_addr", {224'd0, pmem_address}, 256'h1000);
        check("i_only_no_resp", {255'd0, i_pmem_resp}, 256'd0);
        tick(); settle();
        tick(); settle();
        check("i_only_hold_addr", {224'd0, pmem_address}, 256'h1000);
        pmem_resp   = 1'b1;
        i_pmem_read = 1'b0;
        settle();
        check("i_only_resp", {255'd0, i_pmem_resp}, 256'd1);
        check("i_only_d_resp", {255'd0, d_pmem_resp}, 256'd0);
        tick();
        pmem_resp = 1'b0;
        settle();
        check("i_only_back_idle", {254'd0, dbg_state}, {254'd0, S_IDLE});
        check("i_only_resp_gone", {255'd0, i_pmem_resp}, 256'd0);
        check("i_only_read_gone", {255'd0, pmem_read}, 256'd0);

        // Simultaneous request right after reset: I first, then D write
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_0200;
        d_pmem_wdata   = {32{8'hA5}};
        tick(); settle();
        check("tie_first_i", {254'd0, dbg_state}, {254'd0, S_SERVE_I});
        check("tie_i_addr", {224'd0, pmem_address}, 256'h100);
        check("tie_i_no_write", {255'd0, pmem_write}, 256'd0);
        pmem_resp   = 1'b1;
        i_pmem_read = 1'b0;
        settle();
        check("tie_i_resp", {255'd0, i_pmem_resp}, 256'd1);
        check("tie_i_no_d_resp", {255'd0, d_pmem_resp}, 256'd0);
        tick();
        pmem_resp = 1'b0;
        settle();
        check("tie_gap_no_write", {255'd0, pmem_write}, 256'd0);
        tick(); settle();
        check("tie_then_d", {254'd0, dbg_state}, {254'd0, S_SERVE_D});
        check("tie_d_write", {255'd0, pmem_write}, 256'd1);
        check("tie_d_no_read", {255'd0, pmem_read}, 256'd0);
        check("tie_d_addr", {224'd0, pmem_address}, 256'h200);
        check("tie_d_wdata", pmem_wdata, {32{8'hA5}});
        d_pmem_wdata = {32{8'h3C}};   // changes after grant must not leak through
        tick(); settle();
        check("tie_d_wdata_held", pmem_wdata, {32{8'hA5}});
        pmem_resp    = 1'b1;
        d_pmem_write = 1'b0;
        settle();
        check("tie_d_resp", {255'd0, d_pmem_resp}, 256'd1);
        check("tie_d_no_i_resp", {255'd0, i_pmem_resp}, 256'd0);
        tick();
        pmem_resp = 1'b0;
        settle();
        check("tie_d_resp_gone", {255'd0, d_pmem_resp}, 256'd0);

        // Alternation with both requesters held continuously
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0A00;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0B00;
        exp_q.push_back({254'd0, S_SERVE_I});
        exp_q.push_back({254'd0, S_SERVE_D});
        exp_q.push_back({254'd0, S_SERVE_I});
        exp_q.push_back({254'd0, S_SERVE_D});
        while (exp_q.size() > 0) begin
            exp_grant = exp_q.pop_front();
            wait_grant(st);
            check("alt_grant", {254'd0, st}, exp_grant);
            pmem_resp = 1'b1;
            settle();
            check("alt_i_resp", {255'd0, i_pmem_resp},
                  {255'd0, exp_grant[1:0] == S_SERVE_I});
            check("alt_d_resp", {255'd0, d_pmem_resp},
                  {255'd0, exp_grant[1:0] == S_SERVE_D});
            tick();
            pmem_resp = 1'b0;
        end
        idle_inputs();
        tick(); settle();

        // D read dropped one cycle after grant
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0300;
        tick(); settle();
        check("drop_state", {254'd0, dbg_state}, {254'd0, S_SERVE_D});
        check("drop_read", {255'd0, pmem_read}, 256'd1);
        tick();
        d_pmem_read    = 1'b0;
        d_pmem_address = 32'hDEAD_0000;
        settle();
        check("drop_addr_held", {224'd0, pmem_address}, 256'h300);
        tick(); settle();
        check("drop_addr_held2", {224'd0, pmem_address}, 256'h300);
        check("drop_read_held", {255'd0, pmem_read}, 256'd1);
        pmem_resp = 1'b1;
        settle();
        check("drop_resp", {255'd0, d_pmem_resp}, 256'd1);
        tick();
        pmem_resp = 1'b0;
        settle();

        // Read and write together from D are taken as a write
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_0700;
        d_pmem_wdata   = {8{32'h1234_5678}};
        tick(); settle();
        check("rw_write", {255'd0, pmem_write}, 256'd1);
        check("rw_no_read", {255'd0, pmem_read}, 256'd0);
        check("rw_wdata", pmem_wdata, {8{32'h1234_5678}});
        pmem_resp = 1'b1;
        idle_inputs();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;

        // Reset mid-transaction: I served last, so reset must restore D as last
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0040;
        tick();
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b1;
        tick();
        pmem_resp      = 1'b0;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_0400;
        d_pmem_wdata   = {32{8'h5A}};
        tick(); settle();
        check("mid_rst_serve_d", {254'd0, dbg_state}, {254'd0, S_SERVE_D});
        check("mid_rst_write_pre", {255'd0, pmem_write}, 256'd1);
        pmem_resp = 1'b1;
        rst_n     = 1'b0;
        settle();
        check("mid_rst_write_off", {255'd0, pmem_write}, 256'd0);
        check("mid_rst_no_d_resp", {255'd0, d_pmem_resp}, 256'd0);
        check("mid_rst_no_i_resp", {255'd0, i_pmem_resp}, 256'd0);
        check("mid_rst_addr_clr", {224'd0, pmem_address}, 256'd0);
        check("mid_rst_wdata_clr", pmem_wdata, 256'd0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0500;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0600;
        tick(); settle();
        check("post_rst_tie_i", {254'd0, dbg_state}, {254'd0, S_SERVE_I});
        check("post_rst_addr", {224'd0, pmem_address}, 256'h500);
        pmem_resp = 1'b1;
        idle_inputs();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        settle();

        // Spurious pmem_resp in IDLE
        pmem_resp = 1'b1;
        settle();
        check("spur_i_resp", {255'd0, i_pmem_resp}, 256'd0);
        check("spur_d_resp", {255'd0, d_pmem_resp}, 256'd0);
        tick(); settle();
        check("spur_state", {254'd0, dbg_state}, {254'd0, S_IDLE});
        check("spur_read", {255'd0, pmem_read}, 256'd0);
        check("spur_write", {255'd0, pmem_write}, 256'd0);
        pmem_resp = 1'b0;
        tick();

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
